// File: rtl/i2c_arb_pkg.sv
// rtl/i2c_arb_pkg.sv - shared types and constants for the i2c request arbiter
package i2c_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        RESP,
        RECOVER
    } arb_state_e;

    localparam int   RST_CYC_DEF = 4;

    localparam logic OP_WR = 1'b0;
    localparam logic OP_RD = 1'b1;

endpackage

// File: rtl/i2c_req_arbiter_if.sv
// rtl/i2c_req_arbiter_if.sv - signal bundle between the arbiter and the shared i2c master
interface i2c_req_arbiter_if;

    logic       m_newd;
    logic       m_op;
    logic [6:0] m_addr;
    logic [7:0] m_din;
    logic       m_rst;
    logic [7:0] m_dout;
    logic       m_busy;
    logic       m_ack_err;
    logic       m_done;

    // arbiter side
    modport master (
        output m_newd, m_op, m_addr, m_din, m_rst,
        input  m_dout, m_busy, m_ack_err, m_done
    );

    // i2c master side
    modport slave (
        input  m_newd, m_op, m_addr, m_din, m_rst,
        output m_dout, m_busy, m_ack_err, m_done
    );

endinterface

// File: rtl/i2c_rr_pick.sv
// rtl/i2c_rr_pick.sv - combinational round-robin picker starting after the last grant
module i2c_rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [IW-1:0] pos;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = '0;
        // Search last+1 .. last+NREQ, so the previous winner is checked last.
        for (int k = 1; k <= NREQ; k++) begin
            pos = IW'((int'(last) + k) % NREQ);
            if (!any && req[pos]) begin
                any      = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/i2c_req_arbiter.sv
// rtl/i2c_req_arbiter.sv - round-robin sharing of one i2c master with a per-transaction watchdog
module i2c_req_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int TIMEOUT_CYC = 65535,
    parameter int RST_CYC     = RST_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_newd,
    input  logic [NREQ-1:0]      req_op,
    input  logic [7*NREQ-1:0]    req_addr,
    input  logic [8*NREQ-1:0]    req_din,
    output logic [NREQ-1:0]      req_gnt,
    output logic [NREQ-1:0]      req_done,
    output logic                 req_err,
    output logic                 req_timeout,
    output logic [7:0]           rdata,
    i2c_req_arbiter_if.master    mbus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC + 1) : 1;

    arb_state_e      state, state_n;
    logic [IW-1:0]   last_grant;
    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic [CW-1:0]   cnt;
    logic [RW-1:0]   rcnt;
    logic            op_q;
    logic [6:0]      addr_q;
    logic [7:0]      din_q;
    logic            err_q;
    logic            start;
    logic            wd_expire;
    logic            rec_last;
    logic            in_xfer;

    i2c_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req  (req_newd),
        .last (last_grant),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign wd_expire = (cnt == CW'(TIMEOUT_CYC - 1));
    assign rec_last  = (rcnt == RW'(RST_CYC - 1));
    assign in_xfer   = (state == ISSUE) || (state == WAIT_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        start   = 1'b0;
        case (state)
            IDLE: begin
                if (!mbus.m_busy && pick_any) begin
                    start   = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (wd_expire) begin
                    state_n = RECOVER;
                end else if (mbus.m_busy) begin
                    state_n = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // A done arriving on the expiry cycle still counts as a normal completion.
                if (mbus.m_done) begin
                    state_n = RESP;
                end else if (wd_expire) begin
                    state_n = RECOVER;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            RECOVER: begin
                if (rec_last) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= IW'(NREQ - 1);
            req_gnt    <= '0;
            op_q       <= OP_WR;
            addr_q     <= '0;
            din_q      <= '0;
            cnt        <= '0;
            rcnt       <= '0;
            rdata      <= '0;
            err_q      <= 1'b0;
        end else begin
            if (start) begin
                req_gnt    <= pick_gnt;
                last_grant <= pick_idx;
                op_q       <= req_op[pick_idx];
                addr_q     <= req_addr[7*pick_idx +: 7];
                din_q      <= req_din[8*pick_idx +: 8];
                cnt        <= '0;
            end else if (in_xfer && cnt != CW'(TIMEOUT_CYC)) begin
                cnt <= cnt + CW'(1);
            end

            if (state == WAIT_DONE && mbus.m_done) begin
                err_q <= mbus.m_ack_err;
                if (op_q == OP_RD) begin
                    rdata <= mbus.m_dout;
                end
            end

            if (state == RECOVER) begin
                rcnt <= rcnt + RW'(1);
            end else begin
                rcnt <= '0;
            end

            if (state == RESP || (state == RECOVER && rec_last)) begin
                req_gnt <= '0;
            end
        end
    end

    // Completion strobes are suppressed while rst is high so an aborted owner sees nothing.
    assign req_done    = (!rst && (state == RESP || (state == RECOVER && rec_last))) ? req_gnt : '0;
    assign req_err     = !rst && (state == RESP) && err_q;
    assign req_timeout = !rst && (state == RECOVER) && rec_last;

    assign mbus.m_newd = !rst && (state == ISSUE);
    assign mbus.m_op   = op_q;
    assign mbus.m_addr = addr_q;
    assign mbus.m_din  = din_q;
    assign mbus.m_rst  = rst || (state == RECOVER);

endmodule
